// File: rtl/ram2e_cmd_seq.sv
// RAM2E bank register with an unlock-prefix command channel.
// Plain writes load the bank address; FF 00 55 AA C1 AD <cmd> <arg> reaches config functions.
module ram2e_cmd_seq #(
    parameter int unsigned SEQ_TIMEOUT = 4095,
    parameter logic [7:0]  MASK_RST    = 8'h3F
) (
    input  logic       C14M,
    input  logic       RST,
    input  logic       WrStb,
    input  logic [7:0] WrData,
    output logic [7:0] BA,
    output logic [7:0] BankMask,
    output logic       Locked,
    output logic       CmdStb,
    output logic [7:0] CmdCode,
    output logic [7:0] CmdArg
);

    localparam int unsigned CntW = (SEQ_TIMEOUT > 0) ? $clog2(SEQ_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TmoMax = CntW'(SEQ_TIMEOUT);

    typedef enum logic [2:0] {
        StSeq0, StSeq1, StSeq2, StSeq3, StSeq4, StSeq5, StCmd, StArg
    } state_e;

    state_e          state;
    logic [CntW-1:0] tmo_cnt;
    logic [7:0]      pend;

    function automatic logic [7:0] prefix_byte(input state_e s);
        logic [7:0] b;
        unique case (s)
            StSeq0:  b = 8'hFF;
            StSeq1:  b = 8'h00;
            StSeq2:  b = 8'h55;
            StSeq3:  b = 8'hAA;
            StSeq4:  b = 8'hC1;
            StSeq5:  b = 8'hAD;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge C14M) begin
        if (RST) begin
            state    <= StSeq0;
            tmo_cnt  <= '0;
            pend     <= '0;
            BA       <= '0;
            BankMask <= MASK_RST;
            Locked   <= 1'b0;
            CmdStb   <= 1'b0;
            CmdCode  <= '0;
            CmdArg   <= '0;
        end else begin
            CmdStb <= 1'b0;

            if (WrStb) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TmoMax) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (WrStb) begin
                unique case (state)
                    StCmd: begin
                        pend  <= WrData;
                        state <= StArg;
                    end
                    StArg: begin
                        CmdCode <= pend;
                        CmdArg  <= WrData;
                        CmdStb  <= 1'b1;
                        state   <= StSeq0;
                        if (pend == 8'h01) begin
                            BankMask <= WrData;
                            BA       <= BA & WrData;
                        end
                        if (pend == 8'h02) begin
                            Locked <= WrData[0];
                        end
                    end
                    default: begin
                        // Prefix bytes double as ordinary bank selects.
                        if (!Locked) begin
                            BA <= WrData & BankMask;
                        end
                        if (WrData == prefix_byte(state)) begin
                            state <= (state == StSeq5) ? StCmd : state_e'(state + 3'd1);
                        end else begin
                            // FF is only ever the first prefix byte, so it restarts the match.
                            state <= (WrData == 8'hFF) ? StSeq1 : StSeq0;
                        end
                    end
                endcase
            end else if (state != StSeq0 && tmo_cnt == TmoMax) begin
                state <= StSeq0;
                pend  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ram2e_cmd_seq.sv
// Randomized scoreboard bench for ram2e_cmd_seq against a history-based reference model.
module tb_ram2e_cmd_seq;

    localparam int unsigned TO = 4095;

    logic       C14M = 1'b0;
    logic       RST = 1'b1;
    logic       WrStb = 1'b0;
    logic [7:0] WrData = 8'h00;
    logic [7:0] BA, BankMask, CmdCode, CmdArg;
    logic       Locked, CmdStb;

    ram2e_cmd_seq #(.SEQ_TIMEOUT(TO), .MASK_RST(8'h3F)) dut (
        .C14M     (C14M),
        .RST      (RST),
        .WrStb    (WrStb),
        .WrData   (WrData),
        .BA       (BA),
        .BankMask (BankMask),
        .Locked   (Locked),
        .CmdStb   (CmdStb),
        .CmdCode  (CmdCode),
        .CmdArg   (CmdArg)
    );

    always #5 C14M = ~C14M;

    typedef struct packed {
        logic [7:0]  ba;
        logic [7:0]  mask;
        logic        locked;
        logic        stb;
        logic [7:0]  code;
        logic [7:0]  arg;
        int unsigned due;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned edge_n = 0;

    // Reference model state
    logic [7:0]  pfx[6] = '{8'hFF, 8'h00, 8'h55, 8'hAA, 8'hC1, 8'hAD};
    logic [7:0]  hist[$];
    int          phase;           // 0 prefix matching, 1 expect command, 2 expect argument
    logic [7:0]  m_ba, m_mask, m_code, m_arg, m_pend;
    logic        m_locked, m_stb;
    int unsigned last_edge;

    task automatic model_reset();
        hist.delete();
        phase = 0;
        m_ba = 8'h00; m_mask = 8'h3F; m_locked = 1'b0;
        m_code = 8'h00; m_arg = 8'h00; m_pend = 8'h00; m_stb = 1'b0;
        last_edge = edge_n;
    endtask

    // Longest tail of the byte history that equals the start of the prefix.
    function automatic int matched_len();
        int n = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= hist.size()) begin
                bit ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (hist[hist.size() - k + i] != pfx[i]) ok = 1'b0;
                end
                if (ok) n = k;
            end
        end
        return n;
    endfunction

    task automatic model_strobe(input logic [7:0] d);
        m_stb = 1'b0;
        if (edge_n - last_edge - 1 > TO) begin
            hist.delete();
            phase = 0;
        end
        case (phase)
            0: begin
                if (!m_locked) m_ba = d & m_mask;
                hist.push_back(d);
                if (hist.size() > 6) void'(hist.pop_front());
                if (matched_len() == 6) begin
                    phase = 1;
                    hist.delete();
                end
            end
            1: begin
                m_pend = d;
                phase = 2;
            end
            default: begin
                m_code = m_pend;
                m_arg = d;
                m_stb = 1'b1;
                if (m_pend == 8'h01) begin
                    m_mask = d;
                    m_ba = m_ba & d;
                end
                if (m_pend == 8'h02) m_locked = d[0];
                phase = 0;
            end
        endcase
        last_edge = edge_n;
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rst);
        exp_t e;
        WrStb = wr;
        WrData = d;
        RST = rst;
        @(posedge C14M);
        edge_n++;
        if (rst || wr) begin
            if (rst) model_reset();
            else model_strobe(d);
            e.ba = m_ba; e.mask = m_mask; e.locked = m_locked; e.stb = rst ? 1'b0 : m_stb;
            e.code = m_code; e.arg = m_arg; e.due = edge_n;
            expq.push_back(e);
        end
        #1;
        WrStb = 1'b0;
        RST = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_prefix();
        for (int i = 0; i < 6; i++) send(pfx[i]);
    endtask

    // Monitor: pop the expectation for each strobe/reset cycle; elsewhere CmdStb must be idle.
    always @(negedge C14M) begin
        exp_t e;
        if (expq.size() > 0 && expq[0].due == edge_n) begin
            e = expq.pop_front();
            checks++;
            if (BA !== e.ba || BankMask !== e.mask || Locked !== e.locked || CmdStb !== e.stb ||
                CmdCode !== e.code || CmdArg !== e.arg) begin
                errors++;
                $display("FAIL outputs edge %0d: got BA=%h mask=%h lk=%b stb=%b code=%h arg=%h want BA=%h mask=%h lk=%b stb=%b code=%h arg=%h",
                         edge_n, BA, BankMask, Locked, CmdStb, CmdCode, CmdArg,
                         e.ba, e.mask, e.locked, e.stb, e.code, e.arg);
            end
        end else if (edge_n > 0) begin
            checks++;
            if (CmdStb !== 1'b0) begin
                errors++;
                $display("FAIL cmdstb_idle edge %0d: got %b want 0", edge_n, CmdStb);
            end
        end
    end

    initial begin
        int r;
        logic [7:0] b;
        model_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        send(8'hFF); idle(2);                                     // plain write -> 3F
        send_prefix(); send(8'h01); send(8'h0F); idle(1); send(8'h3A); idle(1);
        send_prefix(); send(8'h02); send(8'h01); send(8'h05); idle(1);   // lock
        send_prefix(); send(8'h02); send(8'h00); send(8'h05); idle(1);   // unlock
        send_prefix(); send(8'h01); send(8'hFF); idle(1);                 // restore mask
        send(8'hFF); send(8'h00); send(8'h55);
        send_prefix(); send(8'h7E); send(8'h33); idle(1);                 // resync via FF
        send_prefix(); idle(TO + 1); send(8'h01); send(8'h0F);            // timeout aborts
        send_prefix(); idle(TO); send(8'h01); send(8'h3F); idle(1);       // strobe on expiry
        send_prefix(); send(8'h01); idle(TO + 1); send(8'h0F); idle(1);   // timeout in ARG
        send_prefix(); send(8'h01); step(1'b1, 8'h0F, 1'b1); idle(2);     // RST beats WrStb

        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(1'b0, 8'h00, 1'b1);
            end else if (r < 30) begin
                send_prefix();
                r = $urandom_range(0, 3);
                b = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom_range(0, 255));
                send(b);
                b = (b == 8'h01 && $urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
                send(b);
            end else begin
                r = $urandom_range(0, 6);
                b = (r < 6) ? pfx[r] : 8'($urandom_range(0, 255));
                send(b);
            end
            r = $urandom_range(0, 199);
            if (r == 0) idle(TO);
            else if (r == 1) idle(TO + 1);
            else idle($urandom_range(0, 3));
        end

        idle(3);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
